fetch_db_store: RTL and testbench
=================================

FETCH_DB_STORE -- requirements
Module: fetch_db_store

Interface
REQ-001 SHALL have parameter LUMA_ROWS, default 128, number of 32-pixel luma rows per LCU (64x64 luma).
REQ-002 SHALL have parameter CHROMA_ROWS, default 64, number of 32-pixel chroma rows per LCU (u/v interleaved uvuv...).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ext_store_ready_i  input  1  level; a completed LCU is available in the deblock buffer.
REQ-006 SHALL have port ext_store_en_o  output  1  deblock buffer read enable.
REQ-007 SHALL have port ext_store_addr_o  output  8  deblock buffer row address.
REQ-008 SHALL have port ext_store_data_i  input  32*`PIXEL_WIDTH  row data, valid the cycle after ext_store_en_o.
REQ-009 SHALL have port ext_store_done_o  output  1  one-cycle pulse; LCU fully drained.
REQ-010 SHALL have port bus_valid_o  output  1  outbound row valid.
REQ-011 SHALL have port bus_ready_i  input  1  outbound sink accepts the row when valid and ready are both high.
REQ-012 SHALL have port bus_data_o  output  32*`PIXEL_WIDTH  outbound row pixels.
REQ-013 SHALL have port bus_row_o  output  8  row index of bus_data_o (0..LUMA_ROWS+CHROMA_ROWS-1).
REQ-014 SHALL have port bus_sel_o  output  1  0 = luma row, 1 = chroma row.
REQ-015 SHALL have port bus_last_o  output  1  high with the final row of the LCU.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE -> READ SHALL occur when ext_store_ready_i = 1; otherwise the FSM SHALL stay in IDLE.
REQ-018 In READ, the block SHALL issue reads with ext_store_addr_o = read counter, starting at 0 and incrementing by 1 per issued read.
REQ-019 A read SHALL issue only when the 2-entry output FIFO has room after counting occupied entries plus any read still in flight; the FIFO SHALL never overflow.
REQ-020 ext_store_data_i SHALL be captured into the FIFO exactly one cycle after its ext_store_en_o, together with its row index.
REQ-021 READ -> DRAIN SHALL occur on issue of row LUMA_ROWS+CHROMA_ROWS-1 (191 with defaults); no reads SHALL be issued outside READ.
REQ-022 DRAIN -> DONE SHALL occur when the last row is accepted (bus_valid_o & bus_ready_i & bus_last_o).
REQ-023 In DONE, ext_store_done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 A new LCU SHALL NOT start in the cycle after DONE unless ext_store_ready_i is still 1 in IDLE; back-to-back LCUs are allowed.
REQ-025 bus_valid_o SHALL equal FIFO-not-empty; bus_data_o/bus_row_o/bus_sel_o/bus_last_o SHALL come from the FIFO head and stay stable while bus_valid_o = 1 and bus_ready_i = 0.
REQ-026 bus_sel_o SHALL be 1 iff bus_row_o >= LUMA_ROWS; bus_last_o SHALL be 1 iff bus_row_o = LUMA_ROWS+CHROMA_ROWS-1.
REQ-027 With bus_ready_i held at 1, the block SHALL sustain one row per cycle; the first bus_valid_o SHALL occur 2 cycles after leaving IDLE.
REQ-028 When the FIFO is full, a simultaneous pop and capture in the same cycle SHALL be legal and preserve order.
REQ-029 If ext_store_ready_i falls mid-LCU, the block SHALL ignore it and complete the LCU.
REQ-030 Row counter and FIFO pointers SHALL wrap only via FSM reset to 0 at IDLE entry; the counter SHALL never exceed 191.

Reset
REQ-031 On rstn low, asynchronously: FSM = IDLE, counters/FIFO = empty, ext_store_en_o = 0, ext_store_addr_o = 0, ext_store_done_o = 0, bus_valid_o = 0, bus_data_o = 0, bus_row_o = 0, bus_sel_o = 0, bus_last_o = 0.
REQ-032 Reset asserted mid-LCU SHALL abort the transfer; no done pulse SHALL be emitted, and after release the next LCU SHALL start at row 0.

Verification
REQ-033 ready = 1, bus_ready_i = 1 always, RAM model data = row index -> 192 rows out in order 0..191, sel toggles at row 128, last on 191, one done pulse, 194 cycles from start to last beat.
REQ-034 bus_ready_i random 30% -> no row lost or duplicated, data stable while stalled, FIFO occupancy never > 2.
REQ-035 bus_ready_i = 0 for 50 cycles after start -> at most 2 reads issued, then the block resumes at row 2 when ready rises.
REQ-036 ext_store_ready_i dropped at row 60 -> all 192 rows still delivered, done pulse emitted.
REQ-037 rstn pulsed at row 100 -> all outputs 0 immediately; the next LCU restarts at addr 0 with no done pulse from the aborted LCU.
REQ-038 ready held high across two LCUs -> 384 rows, 2 done pulses, second LCU addr restarts at 0.

Source files
------------

// File: rtl/fetch_db_store.sv
// Drains one deblocked LCU (luma rows, then interleaved chroma rows) from the
// deblock buffer onto a valid/ready row bus through a 2-entry skid FIFO.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module fetch_db_store #(
  parameter int LUMA_ROWS   = 128,
  parameter int CHROMA_ROWS = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ext_store_ready_i,
  output logic                        ext_store_en_o,
  output logic [7:0]                  ext_store_addr_o,
  input  logic [32*`PIXEL_WIDTH-1:0]  ext_store_data_i,
  output logic                        ext_store_done_o,
  output logic                        bus_valid_o,
  input  logic                        bus_ready_i,
  output logic [32*`PIXEL_WIDTH-1:0]  bus_data_o,
  output logic [7:0]                  bus_row_o,
  output logic                        bus_sel_o,
  output logic                        bus_last_o
);

  localparam int         DW       = 32*`PIXEL_WIDTH;
  localparam logic [7:0] LAST_ROW = 8'(LUMA_ROWS + CHROMA_ROWS - 1);
  localparam logic [7:0] LUMA_LIM = 8'(LUMA_ROWS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    row;
  } ent_t;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       infl_q;        // a read issued last cycle returns data now
  logic [7:0] tag_q;         // row index of that in-flight read
  ent_t       fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] occ_q;
  logic       pop, room;
  logic [2:0] load;
  ent_t       head;

  assign pop  = bus_valid_o & bus_ready_i;
  // Next-cycle occupancy must leave a slot for a read issued now.
  assign load = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
  assign room = (load < 3'd2);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ext_store_en_o   = 1'b0;
    ext_store_done_o = 1'b0;
    case (state_q)
      IDLE:  if (ext_store_ready_i) state_d = READ;
      READ:  if (room) begin
               ext_store_en_o = 1'b1;
               if (cnt_q == LAST_ROW) state_d = DRAIN;
               else                   cnt_d   = cnt_q + 8'd1;
             end
      DRAIN: if (pop && bus_last_o) state_d = DONE;
      DONE:  begin
               ext_store_done_o = 1'b1;
               cnt_d            = '0;
               state_d          = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  assign ext_store_addr_o = cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      infl_q    <= 1'b0;
      tag_q     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      infl_q  <= ext_store_en_o;
      tag_q   <= ext_store_addr_o;
      occ_q   <= occ_q + {1'b0, infl_q} - {1'b0, pop};
      if (infl_q) begin
        fifo_q[wr_ptr_q] <= '{data: ext_store_data_i, row: tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (state_q == DONE) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end
    end
  end

  assign head        = fifo_q[rd_ptr_q];
  assign bus_valid_o = (occ_q != 2'd0);
  assign bus_data_o  = head.data;
  assign bus_row_o   = head.row;
  assign bus_sel_o   = (head.row >= LUMA_LIM);
  assign bus_last_o  = (head.row == LAST_ROW);

endmodule

// File: tb/tb_fetch_db_store.sv
// Randomized bench: a buffer RAM model feeds the block, a scoreboard expects
// rows 0..N-1 per LCU in order with pixel content derived from the row index.
`timescale 1ns/1ps
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_fetch_db_store;
  localparam int LR = 128, CR = 64, NR = LR + CR;
  localparam int PW = `PIXEL_WIDTH, DW = 32*PW;

  logic          clk = 1'b0, rstn = 1'b0, ext_ready = 1'b0, bready = 1'b0;
  logic          en, done, bvalid, sel, last;
  logic [7:0]    addr, brow;
  logic [DW-1:0] rdata = '0, bdata;

  fetch_db_store #(.LUMA_ROWS(LR), .CHROMA_ROWS(CR)) dut (
    .clk(clk), .rstn(rstn), .ext_store_ready_i(ext_ready),
    .ext_store_en_o(en), .ext_store_addr_o(addr), .ext_store_data_i(rdata),
    .ext_store_done_o(done), .bus_valid_o(bvalid), .bus_ready_i(bready),
    .bus_data_o(bdata), .bus_row_o(brow), .bus_sel_o(sel), .bus_last_o(last)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int row);
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) d[i*PW +: PW] = PW'(row + i*37);
    return d;
  endfunction

  // deblock buffer: data valid the cycle after the read enable
  always @(posedge clk) if (en) rdata <= mk_data(int'(addr));

  int cyc = 0, iss = 0, acc = 0, done_cnt = 0, total_rows = 0;
  int first_en = -1, first_vld = -1, last_beat = -1;
  int mode = 0, drop_at = -1;

  initial begin
    logic          prev_stall, prev_done;
    logic [DW-1:0] held_d;
    logic [7:0]    held_r;
    prev_stall = 1'b0; prev_done = 1'b0; held_d = '0; held_r = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (en) begin
          if (iss == 0) first_en = cyc;
          chk("rd_addr", DW'(addr), DW'(iss));
          iss++;
        end
        if (bvalid && first_vld < 0) first_vld = cyc;
        if (bvalid && prev_stall) begin
          chk("stall_data", bdata, held_d);
          chk("stall_row", DW'(brow), DW'(held_r));
        end
        if (bvalid && bready) begin
          chk("row", DW'(brow), DW'(acc));
          chk("data", bdata, mk_data(acc));
          chk("sel", DW'(sel), DW'(acc >= LR));
          chk("last", DW'(last), DW'(acc == NR-1));
          if (acc == NR-1) last_beat = cyc;
          acc++;
          total_rows++;
        end
        chk("outstanding", DW'((iss - acc) <= 2), DW'(1));
        if (done) begin
          chk("done_single", DW'(prev_done), DW'(0));
          chk("done_rows", DW'(acc), DW'(NR));
          chk("done_reads", DW'(iss), DW'(NR));
          done_cnt++;
          iss = 0;
          acc = 0;
        end
        prev_stall = bvalid && !bready;
        held_d     = bdata;
        held_r     = brow;
        prev_done  = done;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    case (mode)
      0:       bready = 1'b1;
      1:       bready = ($urandom_range(0, 99) < 30);
      default: bready = 1'b0;
    endcase
    if (drop_at >= 0 && iss >= drop_at) ext_ready = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("done_timeout", DW'(done_cnt >= n), DW'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},    DW'(en),     DW'(0));
    chk({tag, "_addr"},  DW'(addr),   DW'(0));
    chk({tag, "_done"},  DW'(done),   DW'(0));
    chk({tag, "_valid"}, DW'(bvalid), DW'(0));
    chk({tag, "_data"},  bdata,       '0);
    chk({tag, "_row"},   DW'(brow),   DW'(0));
    chk({tag, "_sel"},   DW'(sel),    DW'(0));
    chk({tag, "_last"},  DW'(last),   DW'(0));
  endtask

  initial begin
    int base, tr, k;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rstn = 1'b1;
    repeat (3) step();
    chk("idle_en", DW'(en), DW'(0));

    // full-rate LCU; ext_ready drops right after start
    first_vld = -1; mode = 0; drop_at = 1; ext_ready = 1'b1;
    wait_done(1, 400);
    chk("first_valid_lat", DW'(first_vld - first_en), DW'(2));
    chk("last_beat_lat", DW'(last_beat - first_en), DW'(NR + 1));
    repeat (5) step();
    chk("idle_after_done", DW'(en), DW'(0));

    // random backpressure, ext_ready dropped at row 60
    mode = 1; drop_at = 60; ext_ready = 1'b1;
    wait_done(2, 3000);
    drop_at = -1;

    // sink stalled for 50 cycles after start
    mode = 2; bready = 1'b0; drop_at = 1; ext_ready = 1'b1;
    repeat (52) step();
    chk("stall_reads", DW'(iss), DW'(2));
    chk("stall_head_row", DW'(brow), DW'(0));
    mode = 0;
    wait_done(3, 400);

    // reset asserted at row 100
    mode = 0; drop_at = 1; ext_ready = 1'b1; k = 0;
    while (acc < 100 && k < 500) begin step(); k++; end
    chk("reach_row100", DW'(acc >= 100), DW'(1));
    base = done_cnt;
    rstn = 1'b0;
    #1;
    chk_zero("abort");
    iss = 0; acc = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) step();
    chk("no_abort_done", DW'(done_cnt), DW'(base));
    chk("abort_idle_en", DW'(en), DW'(0));

    // two LCUs back to back
    drop_at = -1; ext_ready = 1'b1; tr = total_rows;
    wait_done(base + 2, 900);
    ext_ready = 1'b0;
    chk("rows_2lcu", DW'(total_rows - tr), DW'(2*NR));
    repeat (4) step();
    chk("idle_final", DW'(en), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
